// File: rtl/tidc_l1_probe_responder.sv
// -----------------------------------------------------------------------------
// tidc_l1_probe_responder
//
// L1-side agent for the TIDC coherence interface. This block keeps a small
// fully-associative table of line states: address, permission (T or B), a
// dirty flag and the line data. Grants fill the table and local full-line
// stores dirty it. The block answers each probe request from tidc_top with
// one single-cycle ack. The ack carries the shrink/report code and, for a
// dirty line that gives up write permission, the dirty data.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   grant_*_i                    install/update a line (pulse, accepted when
//                                upd_ready_o = 1)
//   wr_*_i                       local full-line store (pulse, accepted when
//                                upd_ready_o = 1)
//   wr_err_o                     pulse, one cycle after a rejected store
//   upd_ready_o                  low only while a probe is being resolved
//   evict_*_o                    victim report, one cycle after a grant that
//                                displaced a valid line
//   probe_req_*_i                probe request, level held until the ack
//   probe_ack_*_o                single-cycle probe acknowledgement
// -----------------------------------------------------------------------------
module tidc_l1_probe_responder #(
   parameter int ENTRIES = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 256
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              grant_valid_i,
   input  logic [ADDR_W-1:0] grant_addr_i,
   input  logic [2:0]        grant_cap_i,
   input  logic [DATA_W-1:0] grant_data_i,

   input  logic              wr_valid_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_err_o,
   output logic              upd_ready_o,

   output logic              evict_valid_o,
   output logic [ADDR_W-1:0] evict_addr_o,
   output logic [DATA_W-1:0] evict_data_o,
   output logic              evict_dirty_o,

   input  logic              probe_req_valid_i,
   input  logic [ADDR_W-1:0] probe_req_addr_i,
   input  logic [2:0]        probe_req_permissions_i,

   output logic              probe_ack_valid_o,
   output logic [ADDR_W-1:0] probe_ack_addr_o,
   output logic [2:0]        probe_ack_permissions_o,
   output logic [DATA_W-1:0] probe_ack_dirty_data_o,
   output logic              probe_ack_has_data_o
);

   localparam int OFFS_W = 5;
   localparam int LINE_W = ADDR_W - OFFS_W;
   localparam int IDX_W  = $clog2(ENTRIES);

   localparam logic [2:0] CAP_TOT = 3'd0;
   localparam logic [2:0] CAP_TOB = 3'd1;

   localparam logic [2:0] REP_TTOB = 3'd0;
   localparam logic [2:0] REP_TTON = 3'd1;
   localparam logic [2:0] REP_BTON = 3'd2;
   localparam logic [2:0] REP_TTOT = 3'd3;
   localparam logic [2:0] REP_BTOB = 3'd4;
   localparam logic [2:0] REP_NTON = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      ACK,
      DRAIN
   } state_e;

   state_e state_q, state_d;

   // Line-state table. A valid entry is either T (isT_q = 1) or B.
   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] isT_q;
   logic [ENTRIES-1:0] dirty_q;
   logic [LINE_W-1:0]  line_q [ENTRIES];
   logic [DATA_W-1:0]  data_q [ENTRIES];
   logic [IDX_W-1:0]   victim_q;

   logic [LINE_W-1:0]  probeLine_q;
   logic [2:0]         probeCap_q;

   logic [2:0]         ackPerm_q;
   logic [DATA_W-1:0]  ackData_q;
   logic               ackHasData_q;

   logic               wrErr_q;
   logic               evictValid_q;
   logic [LINE_W-1:0]  evictLine_q;
   logic [DATA_W-1:0]  evictData_q;
   logic               evictDirty_q;

   logic [LINE_W-1:0]  grantLine;
   logic [LINE_W-1:0]  wrLine;
   logic               grantHit, wrHit, probeHit, freeFound;
   logic [IDX_W-1:0]   grantIdx, wrIdx, probeIdx, freeIdx;

   logic               grantAcc, wrAcc, wrOk, wrReject, grantEvicts;
   logic [IDX_W-1:0]   grantTgt;

   logic [2:0]         probeRep;
   logic               probeInvalidate, probeDemote, probeGivesData;

   // Byte-offset bits never take part in matching.
   logic               unusedOffsetBits;
   assign unusedOffsetBits = ^{grant_addr_i[OFFS_W-1:0], wr_addr_i[OFFS_W-1:0],
                               probe_req_addr_i[OFFS_W-1:0]};

   assign grantLine = grant_addr_i[ADDR_W-1:OFFS_W];
   assign wrLine    = wr_addr_i[ADDR_W-1:OFFS_W];

   // Associative search for the grant, store and held probe, plus the lowest
   // free slot used when a grant misses.
   always_comb begin
      grantHit  = 1'b0;
      grantIdx  = '0;
      wrHit     = 1'b0;
      wrIdx     = '0;
      probeHit  = 1'b0;
      probeIdx  = '0;
      freeFound = 1'b0;
      freeIdx   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (line_q[i] == grantLine)) begin
            grantHit = 1'b1;
            grantIdx = IDX_W'(i);
         end
         if (valid_q[i] && (line_q[i] == wrLine)) begin
            wrHit = 1'b1;
            wrIdx = IDX_W'(i);
         end
         if (valid_q[i] && (line_q[i] == probeLine_q)) begin
            probeHit = 1'b1;
            probeIdx = IDX_W'(i);
         end
         if (!valid_q[i] && !freeFound) begin
            freeFound = 1'b1;
            freeIdx   = IDX_W'(i);
         end
      end
   end

   // Grants take priority over a same-cycle store. Only a store hitting a
   // T line is allowed to modify the table.
   always_comb begin
      grantAcc    = grant_valid_i && upd_ready_o;
      wrAcc       = wr_valid_i && upd_ready_o;
      wrOk        = wrAcc && !grantAcc && wrHit && isT_q[wrIdx];
      wrReject    = wrAcc && !wrOk;
      grantEvicts = !grantHit && !freeFound;
      if (grantHit) begin
         grantTgt = grantIdx;
      end else if (freeFound) begin
         grantTgt = freeIdx;
      end else begin
         grantTgt = victim_q;
      end
   end

   // Probe outcome. Any cap other than toT or toB is treated as toN.
   always_comb begin
      probeRep        = REP_NTON;
      probeInvalidate = 1'b0;
      probeDemote     = 1'b0;
      if (probeHit) begin
         if (isT_q[probeIdx]) begin
            if (probeCap_q == CAP_TOT) begin
               probeRep = REP_TTOT;
            end else if (probeCap_q == CAP_TOB) begin
               probeRep    = REP_TTOB;
               probeDemote = 1'b1;
            end else begin
               probeRep        = REP_TTON;
               probeInvalidate = 1'b1;
            end
         end else begin
            if ((probeCap_q == CAP_TOT) || (probeCap_q == CAP_TOB)) begin
               probeRep = REP_BTOB;
            end else begin
               probeRep        = REP_BTON;
               probeInvalidate = 1'b1;
            end
         end
      end
      // A dirty line probed toT keeps its data and its dirty flag.
      probeGivesData = probeHit && dirty_q[probeIdx] && (probeCap_q != CAP_TOT);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state. DRAIN holds until the requester drops its request so a
   // long-held request is answered once.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (probe_req_valid_i) state_d = LOOKUP;
         LOOKUP:  state_d = ACK;
         ACK:     state_d = DRAIN;
         DRAIN:   if (!probe_req_valid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. Table updates are blocked while the probe resolves.
   always_comb begin
      probe_ack_valid_o = (state_q == ACK);
      upd_ready_o       = (state_q != LOOKUP);
   end

   // Probe capture and registered ack payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         probeLine_q  <= '0;
         probeCap_q   <= '0;
         ackPerm_q    <= '0;
         ackData_q    <= '0;
         ackHasData_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && probe_req_valid_i) begin
            probeLine_q <= probe_req_addr_i[ADDR_W-1:OFFS_W];
            probeCap_q  <= probe_req_permissions_i;
         end
         if (state_q == LOOKUP) begin
            ackPerm_q    <= probeRep;
            ackHasData_q <= probeGivesData;
            ackData_q    <= probeGivesData ? data_q[probeIdx] : '0;
         end
      end
   end

   // Table updates: probe shrink in LOOKUP, otherwise grant or store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         isT_q    <= '0;
         dirty_q  <= '0;
         victim_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            line_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else if (state_q == LOOKUP) begin
         if (probeHit) begin
            if (probeInvalidate) valid_q[probeIdx] <= 1'b0;
            if (probeDemote)     isT_q[probeIdx]   <= 1'b0;
            if (probeGivesData)  dirty_q[probeIdx] <= 1'b0;
         end
      end else if (grantAcc) begin
         valid_q[grantTgt] <= 1'b1;
         isT_q[grantTgt]   <= (grant_cap_i == CAP_TOT);
         dirty_q[grantTgt] <= 1'b0;
         line_q[grantTgt]  <= grantLine;
         data_q[grantTgt]  <= grant_data_i;
         if (grantEvicts) begin
            victim_q <= (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + IDX_W'(1);
         end
      end else if (wrOk) begin
         data_q[wrIdx]  <= wr_data_i;
         dirty_q[wrIdx] <= 1'b1;
      end
   end

   // Store-error and eviction reports, one cycle after the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrErr_q      <= 1'b0;
         evictValid_q <= 1'b0;
         evictLine_q  <= '0;
         evictData_q  <= '0;
         evictDirty_q <= 1'b0;
      end else begin
         wrErr_q      <= wrReject;
         evictValid_q <= grantAcc && grantEvicts;
         if (grantAcc && grantEvicts) begin
            evictLine_q  <= line_q[victim_q];
            evictData_q  <= data_q[victim_q];
            evictDirty_q <= dirty_q[victim_q];
         end
      end
   end

   assign wr_err_o                = wrErr_q;
   assign evict_valid_o           = evictValid_q;
   assign evict_addr_o            = {evictLine_q, {OFFS_W{1'b0}}};
   assign evict_data_o            = evictData_q;
   assign evict_dirty_o           = evictDirty_q;
   assign probe_ack_addr_o        = {probeLine_q, {OFFS_W{1'b0}}};
   assign probe_ack_permissions_o = ackPerm_q;
   assign probe_ack_dirty_data_o  = ackData_q;
   assign probe_ack_has_data_o    = ackHasData_q;

endmodule
